st2_cart_loader: RTL and testbench
==================================

Name: st2_cart_loader

Overview:
Upstream feeder for the Studio II RAM/cartridge memory that the CDP1861 video stage and CPU read. Parses an ST2 cartridge image arriving over the HPS ioctl byte stream: validates the 256-byte header, captures the block page map, then relocates every 256-byte data block to its mapped page. Emits a registered single-byte write port into the system bram, plus busy/done/error status for the top level.

Parameters:
CART_INDEX, 8'd1, ioctl_index value selecting ST2 cartridge downloads; other indices ignored.
MAX_BLOCKS, 16, maximum data blocks (page map entries) accepted.
HDR_SIZE, 256, header length in bytes; data starts at this ioctl_addr.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  asynchronous, active-high reset.
ioctl_download  input  1  high for the duration of a download.
ioctl_index  input  8  download type selector.
ioctl_wr  input  1  one-cycle strobe; ioctl_addr/ioctl_dout valid.
ioctl_addr  input  25  byte offset within image.
ioctl_dout  input  8  image byte.
mem_wr  output  1  one-cycle write strobe to bram.
mem_a  output  16  bram write address.
mem_d  output  8  bram write data.
busy  output  1  high while parsing an accepted download.
done  output  1  image loaded successfully; held until next download starts.
error  output  1  image rejected; held until next download starts.

Behaviour:
- Reset (async): state IDLE; mem_wr=0, mem_a=0, mem_d=0, busy=0, done=0, error=0; block count and page map cleared.
- States: IDLE, HEADER, DATA, DONE, ERR.
- Start: rising ioctl_download with ioctl_index==CART_INDEX, from any state -> HEADER; clears done/error, sets busy. Non-matching index: no state change, no writes.
- HEADER: bytes 0..3 must equal 0x52,0x43,0x41,0x32 ("RCA2"); any mismatch -> ERR immediately. Byte 4 = N (total blocks incl. header); N==0 or N-1>MAX_BLOCKS -> ERR. Bytes 64..64+N-2 latched into page map[0..N-2]. No mem_wr during HEADER. After byte HDR_SIZE-1 -> DATA.
- DATA: for ioctl_wr with addr>=HDR_SIZE: k=(addr-HDR_SIZE)>>8, off=addr[7:0]. If k<N-1 and map[k]!=0: next cycle mem_wr=1, mem_a={map[k],off}, mem_d=ioctl_dout. Otherwise byte dropped silently.
- Latency: exactly 1 clk from ioctl_wr to mem_wr; mem_a/mem_d hold until next write. Back-to-back ioctl_wr yields back-to-back mem_wr.
- Falling ioctl_download: in DATA -> DONE (busy=0, done=1); in HEADER -> ERR (truncated). ERR: busy=0, error=1, no further writes.
- ioctl_wr with ioctl_download low: ignored.
- Restart mid-load (new rising download): aborts, returns to HEADER, map cleared; writes already issued are not undone.
- Reset mid-download: immediate IDLE; a pending mem_wr is cancelled.

Optional Feature:
ST2_RAW_EN: when defined, ioctl_index==8'd2 downloads bypass parsing; each byte written linearly to mem_a=ioctl_addr[15:0] with the same 1-clk latency, busy during download, done at end, never error. When undefined, index 2 is ignored like any other non-matching index.

Test Plan:
- Valid image N=3, map[0]=0x04, map[1]=0x07, 768 bytes -> 512 mem_wr; byte at addr 256 -> mem_a=0x0400; addr 767 -> mem_a=0x07FF; done=1, error=0.
- Signature byte 2 = 0x00 -> error=1 the cycle after that byte, zero mem_wr for the rest of the image.
- N=20 with MAX_BLOCKS=16 -> error=1 after byte 4; ioctl_download dropped at byte 100 on a valid header -> error=1 (truncated).
- map[1]=0x00, N=3 -> block 0 written at 0x04xx, block 1 bytes dropped, done=1; extra block past N-1 also dropped.
- Assert reset during DATA with mem_wr pending -> all outputs 0 same cycle; new download afterwards loads normally.
- ST2_RAW_EN defined, index 2, 16 bytes -> mem_a 0x0000..0x000F in order, done=1; undefined -> no mem_wr, done stays 0.

Source files
------------

// File: rtl/st2_cart_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | st2_cart_loader                                                          |
// | Parses an ST2 cartridge image from the ioctl byte stream and relocates   |
// | each 256-byte data block to its mapped bram page. Optional: ST2_RAW_EN   |
// | (ioctl_index 2 loads bytes linearly without parsing).                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module st2_cart_loader #(
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter int         MAX_BLOCKS = 16,
  parameter int         HDR_SIZE   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_wr,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int          c_IDX_W    = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam logic [24:0] c_HDR      = 25'(HDR_SIZE);
  localparam logic [24:0] c_HDR_LAST = 25'(HDR_SIZE - 1);
  localparam logic [24:0] c_MAP_BASE = 25'd64;
  localparam logic [24:0] c_NBLK_POS = 25'd4;
  localparam logic [7:0]  c_NBLK_MAX = 8'(MAX_BLOCKS + 1);
`ifdef ST2_RAW_EN
  localparam logic [7:0]  c_RAW_INDEX = 8'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
`ifdef ST2_RAW_EN
    , S_RAW  = 3'd5
`endif
  } state_t;

  state_t       r_state, w_next;
  logic         r_dl_prev;
  logic [7:0]   r_nblk;
  logic [7:0]   r_map [MAX_BLOCKS];
  logic         r_mem_wr;
  logic [15:0]  r_mem_a;
  logic [7:0]   r_mem_d;

  logic         w_rise, w_fall, w_wr;
  logic [7:0]   w_nm1;
  logic [16:0]  w_blk;
  logic         w_blk_ok;
  logic [24:0]  w_map_off;
  logic         w_hdr_in_map;
  logic [7:0]   w_sig;
  logic         w_load, w_nblk_we, w_map_we, w_mem_we;
  logic [15:0]  w_mem_a;

  assign w_rise = ioctl_download & ~r_dl_prev;
  assign w_fall = ~ioctl_download & r_dl_prev;
  assign w_wr   = ioctl_wr & ioctl_download;
  assign w_nm1  = r_nblk - 8'd1;

  // Data block number counted from the end of the header.
  assign w_blk    = 17'((ioctl_addr - c_HDR) >> 8);
  assign w_blk_ok = (ioctl_addr >= c_HDR) && (w_blk < 17'(w_nm1));

  assign w_map_off    = ioctl_addr - c_MAP_BASE;
  assign w_hdr_in_map = (ioctl_addr >= c_MAP_BASE) && (w_map_off < 25'(w_nm1));

  always_comb begin
    case (ioctl_addr[1:0])
      2'd0:    w_sig = 8'h52;
      2'd1:    w_sig = 8'h43;
      2'd2:    w_sig = 8'h41;
      default: w_sig = 8'h32;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_nblk_we = 1'b0;
    w_map_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_mem_a   = {r_map[w_blk[c_IDX_W-1:0]], ioctl_addr[7:0]};
    if (w_rise && (ioctl_index == CART_INDEX)) begin
      w_next = S_HEADER;
      w_load = 1'b1;
    end
`ifdef ST2_RAW_EN
    else if (w_rise && (ioctl_index == c_RAW_INDEX)) begin
      w_next = S_RAW;
      w_load = 1'b1;
    end
`endif
    else begin
      case (r_state)
        S_HEADER: begin
          if (w_fall) begin
            w_next = S_ERR;
          end else if (w_wr) begin
            if (ioctl_addr < c_NBLK_POS) begin
              if (ioctl_dout != w_sig) w_next = S_ERR;
            end else if (ioctl_addr == c_NBLK_POS) begin
              w_nblk_we = 1'b1;
              if ((ioctl_dout == 8'd0) || (ioctl_dout > c_NBLK_MAX)) w_next = S_ERR;
            end else if (w_hdr_in_map) begin
              w_map_we = 1'b1;
            end
            if (ioctl_addr == c_HDR_LAST) w_next = S_DATA;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            w_next = S_DONE;
          end else if (w_wr && w_blk_ok && (r_map[w_blk[c_IDX_W-1:0]] != 8'd0)) begin
            w_mem_we = 1'b1;
          end
        end
`ifdef ST2_RAW_EN
        S_RAW: begin
          if (w_fall) begin
            w_next = S_DONE;
          end else if (w_wr) begin
            w_mem_we = 1'b1;
            w_mem_a  = ioctl_addr[15:0];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dl_prev <= 1'b0;
      r_nblk    <= 8'd0;
      r_mem_wr  <= 1'b0;
      r_mem_a   <= 16'd0;
      r_mem_d   <= 8'd0;
      for (int i = 0; i < MAX_BLOCKS; i++) r_map[i] <= 8'd0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_mem_wr  <= w_mem_we;
      if (w_mem_we) begin
        r_mem_a <= w_mem_a;
        r_mem_d <= ioctl_dout;
      end
      // A fresh download forgets the previous image's page map.
      if (w_load) begin
        r_nblk <= 8'd0;
        for (int i = 0; i < MAX_BLOCKS; i++) r_map[i] <= 8'd0;
      end else begin
        if (w_nblk_we) r_nblk <= ioctl_dout;
        if (w_map_we)  r_map[w_map_off[c_IDX_W-1:0]] <= ioctl_dout;
      end
    end
  end

  assign mem_wr = r_mem_wr;
  assign mem_a  = r_mem_a;
  assign mem_d  = r_mem_d;
`ifdef ST2_RAW_EN
  assign busy   = (r_state == S_HEADER) || (r_state == S_DATA) || (r_state == S_RAW);
`else
  assign busy   = (r_state == S_HEADER) || (r_state == S_DATA);
`endif
  assign done   = (r_state == S_DONE);
  assign error  = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_st2_cart_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_st2_cart_loader                                                       |
// | Randomised ST2 images checked against a header/page-map reference model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_st2_cart_loader;

  localparam logic [7:0] c_CART       = 8'd1;
  localparam int         c_MAX_BLOCKS = 16;
`ifdef ST2_RAW_EN
  localparam bit         c_RAW        = 1'b1;
`else
  localparam bit         c_RAW        = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_wr;
  logic [15:0] mem_a;
  logic [7:0]  mem_d;
  logic        busy, done, error;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  img[$];
  logic [23:0] got[$];
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  st2_cart_loader #(.CART_INDEX(c_CART), .MAX_BLOCKS(c_MAX_BLOCKS), .HDR_SIZE(256)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_wr(mem_wr), .mem_a(mem_a), .mem_d(mem_d), .busy(busy), .done(done), .error(error)
  );

  always @(negedge clk) if (mem_wr === 1'b1) got.push_back({mem_a, mem_d});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic build(input int n, input int len);
    img.delete();
    for (int a = 0; a < len; a++) img.push_back(8'($urandom));
    img[0] = 8'h52; img[1] = 8'h43; img[2] = 8'h41; img[3] = 8'h32; img[4] = 8'(n);
    for (int k = 0; k < n - 1 && k < c_MAX_BLOCKS; k++)
      img[64+k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  // Index of the header byte that invalidates the image, or -1 for a good header.
  function automatic int model_err_at();
    logic [7:0] sig [4];
    sig[0] = 8'h52; sig[1] = 8'h43; sig[2] = 8'h41; sig[3] = 8'h32;
    for (int i = 0; i < 4; i++) if (img[i] != sig[i]) return i;
    if (img[4] == 8'd0 || int'(img[4]) - 1 > c_MAX_BLOCKS) return 4;
    return -1;
  endfunction

  function automatic bit model_write(input int a, output logic [15:0] wa);
    int k;
    wa = 16'd0;
    if (model_err_at() >= 0 || a < 256) return 1'b0;
    k = (a - 256) / 256;
    if (k >= int'(img[4]) - 1 || img[64+k] == 8'd0) return 1'b0;
    wa = {img[64+k], 8'(a % 256)};
    return 1'b1;
  endfunction

  task automatic run_load(input int nsend, input string tag);
    int          ea, nd;
    bit          w, exp_err;
    logic [15:0] wa;
    got.delete(); exp_q.delete();
    ea = model_err_at();
    exp_err = (ea >= 0) || (nsend < 256);
    ioctl_index = c_CART; ioctl_download = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy"}, busy, (ea == 0 && img[0] != 8'h52) ? 1 : 1);
    for (int a = 0; a < nsend; a++) begin
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      wr_byte(25'(a), img[a]);
      w = model_write(a, wa);
      if (w) exp_q.push_back({wa, img[a]});
      check({tag, " mem_wr"}, mem_wr, w);
      if (w) check({tag, " mem_a/d"}, {mem_a, mem_d}, {wa, img[a]});
      if (a == ea) check({tag, " hdr error"}, error, 1);
    end
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    check({tag, " status"}, {busy, done, error}, {1'b0, !exp_err, exp_err});
    check({tag, " count"}, got.size(), exp_q.size());
    nd = 0;
    for (int i = 0; i < exp_q.size(); i++) if (got[i] !== exp_q[i]) nd++;
    check({tag, " contents"}, nd, 0);
  endtask

  initial begin
    int nd;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    repeat (3) @(posedge clk); #1;
    check("reset outputs", {mem_wr, mem_a, mem_d, busy, done, error}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle outputs", {mem_wr, busy, done, error}, 0);

    build(3, 768); img[64] = 8'h04; img[65] = 8'h07;
    run_load(768, "valid");
    check("valid n512", got.size(), 512);
    check("valid first", got[0][23:8], 16'h0400);
    check("valid last", got[511][23:8], 16'h07FF);

    build(3, 768); img[2] = 8'h00;
    run_load(768, "badsig");

    build(20, 768);
    run_load(768, "n20");

    build(3, 768);
    run_load(100, "trunc");

    build(3, 1024); img[64] = 8'h04; img[65] = 8'h00;
    run_load(1024, "hole");
    check("hole n256", got.size(), 256);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 17);
      build(n, 256 + $urandom_range(0, 256 * n));
      run_load(img.size(), "random");
    end

    build(3, 768); img[64] = 8'h04; img[65] = 8'h07;
    ioctl_index = c_CART; ioctl_download = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a <= 300; a++) wr_byte(25'(a), img[a]);
    check("rst pending wr", mem_wr, 1);
    reset = 1'b1; #1;
    check("rst mid-data", {mem_wr, mem_a, mem_d, busy, done, error}, 0);
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_load(768, "after rst");

    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; @(posedge clk); #1;
    img.delete();
    for (int a = 0; a < 16; a++) img.push_back(8'($urandom));
    got.delete();
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    @(posedge clk); #1;
    check("raw busy", busy, c_RAW);
    for (int a = 0; a < 16; a++) wr_byte(25'(a), img[a]);
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    check("raw count", got.size(), c_RAW ? 16 : 0);
    nd = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== {16'(i), img[i]}) nd++;
    check("raw contents", nd, 0);
    check("raw status", {busy, done, error}, {1'b0, c_RAW, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
